// File: rtl/pt1pt2_cfg_loader.sv
// Serial loader for the macrocell PT1/PT2 routing selects: shadow assembly, atomic commit, serial readback.
// Stream bit k lands in field k%5 of macrocell k/5, tracked with a field counter and a macrocell counter.
module pt1pt2_cfg_loader #(
  parameter int MACROCELLS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [MACROCELLS-1:0] pt1_mux,
  output logic [MACROCELLS-1:0] pt2_mux,
  output logic [MACROCELLS-1:0] xor_a_mux,
  output logic [MACROCELLS-1:0] xor_b_mux,
  output logic [MACROCELLS-1:0] xor_inv_mux,
  input  logic                  rb_start,
  output logic                  rb_bit,
  output logic                  rb_valid
);

  localparam int MW = (MACROCELLS > 1) ? $clog2(MACROCELLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_DONE   = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            f_q, f_d;
  logic [MW-1:0]         m_q, m_d;
  logic                  err_q, err_d;
  logic [MACROCELLS-1:0] shadow_q [5];
  logic [MACROCELLS-1:0] shadow_d [5];
  logic [MACROCELLS-1:0] sel_q    [5];
  logic [MACROCELLS-1:0] sel_d    [5];

  logic last_pos;
  logic load_xfer;
  logic advance;
  logic clear_cnt;

  assign last_pos  = (f_q == 3'd4) && (m_q == MW'(MACROCELLS - 1));
  // cfg_start in LOAD is an abort, so it suppresses the transfer in that cycle
  assign load_xfer = (state_q == S_LOAD) && cfg_valid && !cfg_start;
  assign advance   = load_xfer || (state_q == S_READ);
  assign clear_cnt = ((state_q == S_IDLE) && (cfg_start || rb_start)) ||
                     ((state_q == S_LOAD) && cfg_start);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
        end else if (rb_start) begin
          state_d = S_READ;
        end
      end
      S_LOAD: begin
        if (load_xfer && last_pos) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_READ: begin
        if (last_pos) begin
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; rb_bit comes from registered counters so it holds all cycle
  always_comb begin
    cfg_ready = (state_q == S_LOAD);
    cfg_done  = (state_q == S_DONE);
    rb_valid  = (state_q == S_READ);
    rb_bit    = 1'b0;
    if (state_q == S_READ) begin
      rb_bit = sel_q[f_q][m_q];
    end
  end

  always_comb begin
    f_d      = f_q;
    m_d      = m_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;

    if (clear_cnt) begin
      f_d = 3'd0;
      m_d = '0;
    end else if (advance) begin
      if (f_q == 3'd4) begin
        f_d = 3'd0;
        m_d = (m_q == MW'(MACROCELLS - 1)) ? '0 : m_q + 1'b1;
      end else begin
        f_d = f_q + 3'd1;
      end
    end

    if ((state_q == S_LOAD) && cfg_start) begin
      err_d = 1'b1;
    end
    if (state_q == S_DONE) begin
      err_d = 1'b0;
    end
    if (load_xfer) begin
      shadow_d[f_q][m_q] = cfg_bit;
    end
    if (state_q == S_COMMIT) begin
      sel_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 3'd0;
      m_q   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= '0;
        sel_q[i]    <= '0;
      end
    end else begin
      f_q   <= f_d;
      m_q   <= m_d;
      err_q <= err_d;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= shadow_d[i];
        sel_q[i]    <= sel_d[i];
      end
    end
  end

  assign cfg_err     = err_q;
  assign pt1_mux     = sel_q[0];
  assign pt2_mux     = sel_q[1];
  assign xor_a_mux   = sel_q[2];
  assign xor_b_mux   = sel_q[3];
  assign xor_inv_mux = sel_q[4];

endmodule

// File: tb/tb_pt1pt2_cfg_loader.sv
// Bench for pt1pt2_cfg_loader with two macrocells: directed scenarios plus random loads and readbacks.
// The reference keeps the last committed stream as a bit list; selects and readback derive from k = 5*m + f.
module tb_pt1pt2_cfg_loader;

  localparam int MC    = 2;
  localparam int TOTAL = 5 * MC;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_bit, cfg_valid;
  logic          cfg_ready, cfg_done, cfg_err;
  logic [MC-1:0] pt1_mux, pt2_mux, xor_a_mux, xor_b_mux, xor_inv_mux;
  logic          rb_start, rb_bit, rb_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TOTAL-1:0] ref_cfg;

  pt1pt2_cfg_loader #(.MACROCELLS(MC)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .pt1_mux(pt1_mux), .pt2_mux(pt2_mux), .xor_a_mux(xor_a_mux),
    .xor_b_mux(xor_b_mux), .xor_inv_mux(xor_inv_mux),
    .rb_start(rb_start), .rb_bit(rb_bit), .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected select vector for field f: bit m is stream bit 5*m + f
  function automatic logic [MC-1:0] exp_sel(input logic [TOTAL-1:0] s, input int f);
    logic [MC-1:0] v;
    for (int m = 0; m < MC; m++) v[m] = s[5 * m + f];
    return v;
  endfunction

  task automatic check_sels(input string tag);
    check({tag, " pt1"},  32'(pt1_mux),     32'(exp_sel(ref_cfg, 0)));
    check({tag, " pt2"},  32'(pt2_mux),     32'(exp_sel(ref_cfg, 1)));
    check({tag, " xa"},   32'(xor_a_mux),   32'(exp_sel(ref_cfg, 2)));
    check({tag, " xb"},   32'(xor_b_mux),   32'(exp_sel(ref_cfg, 3)));
    check({tag, " xinv"}, 32'(xor_inv_mux), 32'(exp_sel(ref_cfg, 4)));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
  endtask

  // Send bits [first, last] of s; gap: 0 none, 1 alternate, 2 random
  task automatic send_bits(input logic [TOTAL-1:0] s, input int first, input int last, input int gap);
    int cyc = 0;
    for (int k = first; k <= last; k++) begin
      logic sent = 1'b0;
      while (!sent) begin
        logic v;
        v = (gap == 0) ? 1'b1 : (gap == 1) ? logic'(cyc % 2) : logic'($urandom_range(0, 1));
        if (cyc > 200) v = 1'b1;
        cfg_valid = v;
        cfg_bit   = v ? s[k] : logic'($urandom_range(0, 1));
        @(posedge clk); #1;
        sent = v;
        cyc++;
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Finish a load whose last bit was just transferred; checks commit timing and cfg_err handling
  task automatic finish_load(input string tag, input logic [TOTAL-1:0] s, input logic err_exp);
    @(negedge clk);
    check({tag, " commit done"},  32'(cfg_done),  32'(0));
    check({tag, " commit ready"}, 32'(cfg_ready), 32'(0));
    check({tag, " commit err"},   32'(cfg_err),   32'(err_exp));
    check_sels({tag, " pre"});
    @(negedge clk);
    check({tag, " done pulse"}, 32'(cfg_done), 32'(1));
    ref_cfg = s;
    check_sels({tag, " post"});
    @(negedge clk);
    check({tag, " done end"}, 32'(cfg_done), 32'(0));
    check({tag, " err clr"},  32'(cfg_err),  32'(0));
  endtask

  task automatic do_load(input string tag, input logic [TOTAL-1:0] s, input int gap);
    pulse_start();
    check({tag, " ready"}, 32'(cfg_ready), 32'(1));
    send_bits(s, 0, TOTAL - 1, gap);
    finish_load(tag, s, 1'b0);
  endtask

  task automatic do_readback(input string tag, input bit poke_start);
    int nvalid = 0;
    @(posedge clk); #1 rb_start = 1'b1;
    @(posedge clk); #1 rb_start = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      @(negedge clk);
      if (poke_start && i == 3) cfg_start = 1'b1;
      if (poke_start && i == 5) cfg_start = 1'b0;
      if (rb_valid) nvalid++;
      check({tag, " rb_valid"}, 32'(rb_valid), 32'(i < TOTAL));
      if (i < TOTAL) check({tag, " rb_bit"}, 32'(rb_bit), 32'(ref_cfg[i]));
    end
    check({tag, " rb count"}, 32'(nvalid), 32'(TOTAL));
    check({tag, " idle after rb"}, 32'(cfg_ready), 32'(0));
  endtask

  initial begin
    logic [TOTAL-1:0] s;
    rst = 1'b1; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0; rb_start = 1'b0;
    ref_cfg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_sels("reset");
    check("reset ready", 32'(cfg_ready), 32'(0));
    check("reset done",  32'(cfg_done),  32'(0));
    check("reset err",   32'(cfg_err),   32'(0));
    check("reset rbv",   32'(rb_valid),  32'(0));
    check("reset rbbit", 32'(rb_bit),    32'(0));

    // Stream 1,0,1,1,0,0,1,1,0,1 with bit k at index k
    s = 10'b1011001101;
    do_load("s2", s, 0);
    check("s2 pt1 lit", 32'(pt1_mux), 32'h1);
    check("s2 xinv lit", 32'(xor_inv_mux), 32'h2);
    do_readback("rb", 1'b1);
    do_load("s3", s, 1);

    // Abort after 6 bits, then reload 0,0,0,0,1,1,0,0,0,0
    pulse_start();
    send_bits(10'b1111111111, 0, 5, 0);
    cfg_valid = 1'b1; cfg_bit = 1'b0; cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    check("abort err", 32'(cfg_err), 32'(1));
    check("abort ready", 32'(cfg_ready), 32'(1));
    check_sels("abort");
    s = 10'b0000110000;
    send_bits(s, 0, TOTAL - 1, 0);
    finish_load("s4", s, 1'b1);
    check("s4 xinv lit", 32'(xor_inv_mux), 32'h1);
    check("s4 pt1 lit",  32'(pt1_mux),     32'h2);

    // Reset on the 7th transfer of a load
    pulse_start();
    send_bits(10'b1010101010, 0, 5, 0);
    cfg_valid = 1'b1; cfg_bit = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; cfg_valid = 1'b0;
    ref_cfg = '0;
    @(negedge clk);
    check_sels("mid rst");
    check("mid rst ready", 32'(cfg_ready), 32'(0));
    @(negedge clk);
    check("mid rst idle", 32'(cfg_ready), 32'(0));
    do_load("post rst", 10'b1100111001, 0);

    for (int it = 0; it < 8; it++) begin
      s = TOTAL'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pulse_start();
        send_bits(TOTAL'($urandom), 0, $urandom_range(0, TOTAL - 2), 2);
        cfg_start = 1'b1; cfg_valid = logic'($urandom_range(0, 1));
        @(posedge clk); #1 cfg_start = 1'b0; cfg_valid = 1'b0;
        send_bits(s, 0, TOTAL - 1, 2);
        finish_load("rnd abort", s, 1'b1);
      end else begin
        do_load("rnd", s, 2);
      end
      do_readback("rnd rb", bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
